// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: MEM-stage data-memory port controller.
// Loads with sign/zero extension, word stores in one cycle, and sb/sh
// as a read-modify-write (read old word, then write the merged word).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_*                 EX/MEM memory request (valid, wen, ren, addr,
//                         wdata, maskMode, unsigned)
//   busy                  RMW write phase, port unavailable
//   ld_data, ld_valid     extended load result
//   err                   registered pulse for a dropped bad request
//   ram_*                 single-port sync-read RAM interface
module dmem_rmw_ctrl #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_wen,
    input  logic          req_ren,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [1:0]    req_maskMode,
    input  logic          req_unsigned,
    output logic          busy,
    output logic [31:0]   ld_data,
    output logic          ld_valid,
    output logic          err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RMW  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    r_off;
    logic [1:0]    r_mode;
    logic          r_uns;
    logic [AW-1:0] r_waddr;
    logic [15:0]   r_wdata;
    logic          r_err;

    logic          w_rmw;
    logic          w_mis;
    logic          w_live;
    logic          w_acc;
    logic          w_bad;
    logic          w_wst;
    logic          w_sub;
    logic          w_ld;
    logic [1:0]    w_nxt;
    logic [31:0]   w_shift;
    logic [31:0]   w_ext;
    logic [31:0]   w_merge;
    logic          w_unused;

    assign w_unused = ^req_addr[31:AW+2];

    assign w_rmw  = (r_state == S_RMW);
    assign w_mis  = ((req_maskMode == 2'b01) && req_addr[0]) ||
                    ((req_maskMode == 2'b10) && (req_addr[1:0] != 2'b00));
    // Gated by rst_n so nothing reaches the RAM while reset is held.
    assign w_live = rst_n && req_valid && (req_wen || req_ren) && !w_rmw;
    assign w_acc  = w_live && !w_mis && (req_maskMode != 2'b11);
    assign w_bad  = w_live && (w_mis || (req_maskMode == 2'b11));
    assign w_wst  = w_acc && req_wen && (req_maskMode == 2'b10);
    assign w_sub  = w_acc && req_wen && (req_maskMode != 2'b10);
    assign w_ld   = w_acc && !req_wen;

    always_comb begin
        w_nxt = S_IDLE;
        if (w_rmw)      w_nxt = S_IDLE;
        else if (w_ld)  w_nxt = S_LOAD;
        else if (w_sub) w_nxt = S_RMW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_off   <= '0;
            r_mode  <= '0;
            r_uns   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_err   <= w_bad;
            if (w_acc) begin
                r_off   <= req_addr[1:0];
                r_mode  <= req_maskMode;
                r_uns   <= req_unsigned;
                r_waddr <= req_addr[AW+1:2];
                r_wdata <= req_wdata[15:0];
            end
        end
    end

    assign w_shift = ram_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shift;
        case (r_mode)
            2'b00:   w_ext = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ext = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = w_shift;
        endcase
    end

    // Half-word lane is chosen by addr[1]; addr[0] is zero for halves.
    always_comb begin
        w_merge = ram_rdata;
        if (r_mode == 2'b00)
            w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
    end

    assign busy      = w_rmw;
    assign ld_valid  = (r_state == S_LOAD);
    assign ld_data   = ld_valid ? w_ext : 32'd0;
    assign err       = r_err;
    assign ram_en    = w_rmw || w_acc;
    assign ram_we    = w_rmw || w_wst;
    assign ram_addr  = w_rmw ? r_waddr :
                       (w_acc ? req_addr[AW+1:2] : '0);
    assign ram_wdata = w_rmw ? w_merge :
                       (w_wst ? req_wdata : 32'd0);

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// tb_dmem_rmw_ctrl: directed and random checks of dmem_rmw_ctrl
// against a byte-addressed memory model kept in the bench.
module tb_dmem_rmw_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_wen, req_ren, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_maskMode;
    logic          busy, ld_valid, err, ram_en, ram_we;
    logic [31:0]   ld_data, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wen(req_wen), .req_ren(req_ren),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_maskMode(req_maskMode), .req_unsigned(req_unsigned),
        .busy(busy), .ld_data(ld_data), .ld_valid(ld_valid), .err(err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // environment RAM
    logic [31:0] ram [0:1023];
    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end

    // reference memory, byte granular
    logic [7:0] ref_b [0:4095];

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 0;

    logic        exp_busy, exp_ldv, exp_err, exp_en, exp_we;
    logic [31:0] exp_ld, exp_wd;
    logic [9:0]  exp_addr;

    int          pend;       // 0 none, 1 load result due, 2 RMW write due
    logic        pend_err;
    logic [31:0] pend_ld;
    logic [31:0] rmw_a, rmw_d;
    logic [1:0]  rmw_m;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exv);
        vectors++;
        if (act !== exv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_on) begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("ld_valid", {31'd0, ld_valid}, {31'd0, exp_ldv});
            chk("ld_data", ld_data, exp_ld);
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("ram_en", {31'd0, ram_en}, {31'd0, exp_en});
            chk("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
            chk("ram_addr", {22'd0, ram_addr}, {22'd0, exp_addr});
            chk("ram_wdata", ram_wdata, exp_wd);
        end

    function automatic int nbytes(input logic [1:0] m);
        return (m == 2'b00) ? 1 : ((m == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] a,
                                          input logic [1:0] m, input logic u);
        logic [31:0] v = 0;
        for (int i = 0; i < nbytes(m); i++)
            v[8*i +: 8] = ref_b[int'(a[11:0]) + i];
        if (!u && m == 2'b00) v = 32'($signed(v[7:0]));
        if (!u && m == 2'b01) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    task automatic mstore(input logic [31:0] a, input logic [1:0] m,
                          input logic [31:0] d);
        for (int i = 0; i < nbytes(m); i++)
            ref_b[int'(a[11:0]) + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        int b = int'({a[11:2], 2'b00});
        return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
    endfunction

    task automatic clr_exp();
        exp_busy = 0; exp_ldv = 0; exp_err = 0; exp_en = 0; exp_we = 0;
        exp_ld = 0; exp_wd = 0; exp_addr = 0;
    endtask

    task automatic step(input logic v, input logic wen, input logic ren,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] m, input logic u);
        int  np;
        bit  ne, ok;
        @(posedge clk); #1;
        req_valid = v; req_wen = wen; req_ren = ren; req_addr = a;
        req_wdata = wd; req_maskMode = m; req_unsigned = u;
        clr_exp();
        exp_err = pend_err;
        if (pend == 1) begin exp_ldv = 1; exp_ld = pend_ld; end
        np = 0; ne = 0;
        if (pend == 2) begin
            mstore(rmw_a, rmw_m, rmw_d);
            exp_busy = 1; exp_en = 1; exp_we = 1;
            exp_addr = rmw_a[11:2]; exp_wd = mword(rmw_a);
        end else if (v && (wen || ren)) begin
            ok = (m != 2'b11) && !(m == 2'b01 && a[0]) &&
                 !(m == 2'b10 && a[1:0] != 2'b00);
            if (!ok) ne = 1;
            else begin
                exp_en = 1; exp_addr = a[11:2];
                if (wen && m == 2'b10) begin
                    exp_we = 1; exp_wd = wd; mstore(a, m, wd);
                end else if (wen) begin
                    np = 2; rmw_a = a; rmw_d = wd; rmw_m = m;
                end else begin
                    np = 1; pend_ld = mload(a, m, u);
                end
            end
        end
        pend = np; pend_err = ne;
    endtask

    task automatic bubble();
        step(0, 0, 0, 32'h0, 32'h0, 2'b00, 0);
    endtask

    task automatic rst_cycle();
        @(posedge clk); #1;
        rst_n = 0;
        req_valid = 0; req_wen = 0; req_ren = 0; req_addr = 0;
        req_wdata = 0; req_maskMode = 0; req_unsigned = 0;
        clr_exp();
        pend = 0; pend_err = 0;
        @(negedge clk);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        #1 rst_n = 1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] exv);
        @(negedge clk);
        chk(nm, act, exv);
    endtask

    initial begin
        logic [31:0] x, a, wd;
        logic [1:0]  m;
        int          op;
        rst_n = 0;
        req_valid = 0; req_wen = 0; req_ren = 0; req_addr = 0;
        req_wdata = 0; req_maskMode = 0; req_unsigned = 0;
        clr_exp();
        pend = 0; pend_err = 0;
        for (int w = 0; w < 1024; w++) begin
            x = $urandom;
            ram[w] = x;
            for (int i = 0; i < 4; i++) ref_b[4*w + i] = x[8*i +: 8];
        end
        #1 chk_on = 1;
        @(negedge clk); #1 rst_n = 1;

        step(1, 1, 0, 32'h10, 32'hDEADBEEF, 2'b10, 0);
        step(1, 0, 1, 32'h10, 32'h0, 2'b10, 0);
        bubble();
        lit("lw_v", {31'd0, ld_valid}, 32'd1);
        chk("lw_d", ld_data, 32'hDEADBEEF);

        step(1, 1, 0, 32'h20, 32'h11223344, 2'b10, 0);
        step(1, 1, 0, 32'h21, 32'h000000AA, 2'b00, 0);
        bubble();
        lit("sb_busy", {31'd0, busy}, 32'd1);
        chk("sb_wd", ram_wdata, 32'h1122AA44);
        step(1, 0, 1, 32'h21, 32'h0, 2'b00, 1);
        bubble();
        lit("lbu", ld_data, 32'h000000AA);
        step(1, 0, 1, 32'h21, 32'h0, 2'b00, 0);
        bubble();
        lit("lb", ld_data, 32'hFFFFFFAA);

        step(1, 1, 0, 32'h20, 32'h11223344, 2'b10, 0);
        step(1, 1, 0, 32'h22, 32'h00008001, 2'b01, 0);
        bubble();
        lit("sh_wd", ram_wdata, 32'h80013344);
        step(1, 0, 1, 32'h22, 32'h0, 2'b01, 0);
        bubble();
        lit("lh", ld_data, 32'hFFFF8001);
        step(1, 0, 1, 32'h22, 32'h0, 2'b01, 1);
        bubble();
        lit("lhu", ld_data, 32'h00008001);

        step(1, 1, 0, 32'h23, 32'h00001234, 2'b01, 0);
        lit("mis_sh_en", {31'd0, ram_en}, 32'd0);
        step(1, 0, 1, 32'h12, 32'h0, 2'b10, 0);
        lit("mis_sh_err", {31'd0, err}, 32'd1);
        chk("mis_lw_en", {31'd0, ram_en}, 32'd0);
        bubble();
        lit("mis_lw_err", {31'd0, err}, 32'd1);
        bubble();
        lit("err_once", {31'd0, err}, 32'd0);
        step(1, 0, 1, 32'h20, 32'h0, 2'b10, 0);
        bubble();
        lit("mis_unch", ld_data, 32'h80013344);

        step(1, 1, 0, 32'h0, 32'hA0A0A0A0, 2'b10, 0);
        step(1, 1, 0, 32'h4, 32'hB1B1B1B1, 2'b10, 0);
        step(1, 1, 0, 32'h8, 32'hC2C2C2C2, 2'b10, 0);
        step(1, 0, 1, 32'h0, 32'h0, 2'b10, 0);
        step(1, 0, 1, 32'h4, 32'h0, 2'b10, 0);
        lit("b2b0", ld_data, 32'hA0A0A0A0);
        step(1, 0, 1, 32'h8, 32'h0, 2'b10, 0);
        lit("b2b1", ld_data, 32'hB1B1B1B1);
        bubble();
        lit("b2b2", ld_data, 32'hC2C2C2C2);
        chk("b2b_busy", {31'd0, busy}, 32'd0);

        step(1, 1, 0, 32'h20, 32'h11223344, 2'b10, 0);
        step(1, 1, 0, 32'h20, 32'h00000055, 2'b00, 0);
        rst_cycle();
        step(1, 0, 1, 32'h20, 32'h0, 2'b10, 0);
        bubble();
        lit("rst_unch", ld_data, 32'h11223344);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_cycle();
                continue;
            end
            m  = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 4095));
            wd = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (m == 2'b01) a[0] = 1'b0;
                if (m == 2'b10) a[1:0] = 2'b00;
            end
            op = $urandom_range(0, 9);
            if (pend == 2 && op < 5)
                step(1, op[0], 1, a, wd, m, op[1]);
            else if (pend == 2 || op == 0)
                bubble();
            else if (op < 5)
                step(1, 0, 1, a, wd, m, op[0]);
            else
                step(1, 1, op == 9, a, wd, m, 0);
        end
        bubble();
        bubble();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
